// File: rtl/pipe_hazard_if.sv
// Hazard-controller bundle between the 5-stage pipeline datapath and the
// central hazard controller.
//
// master : pipeline/datapath side. It drives the stage register specifiers
//          and status bits, and consumes the forwarding selects, the stage
//          enables/flushes and the counters.
// slave  : hazard controller side (pipe_hazard_ctrl).
//
// Signals (datapath -> controller):
//   id_rs, id_rt        [REG_AW]  source regs of instr in IF/ID
//   id_uses_rs/rt                 IF/ID instr actually reads rs / rt
//   ex_rs, ex_rt        [REG_AW]  source regs of instr in ID/EX
//   ex_mem_read                   ID/EX instr is a load
//   ex_write_reg        [REG_AW]  ID/EX destination
//   mem_reg_write                 EX/MEM writes regfile
//   mem_write_reg       [REG_AW]  EX/MEM destination
//   mem_access                    EX/MEM instr is load or store
//   branch_taken                  resolved taken branch (MEM stage)
//   wb_reg_write                  MEM/WB writes regfile
//   wb_write_reg        [REG_AW]  MEM/WB destination
// Signals (controller -> datapath):
//   fwd_a, fwd_b        [2]       00 ID/EX, 10 EX/MEM, 01 MEM/WB
//   pc_en, if_id_en, id_ex_en, ex_mem_en   register load enables
//   if_id_flush, id_ex_flush, ex_mem_flush load NOP into that register
//   mem_wb_bubble                 load NOP into MEM/WB
//   stall_cnt, flush_cnt [CNT_W]  saturating event counters
interface pipe_hazard_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_write_reg;
    logic              mem_reg_write;
    logic [REG_AW-1:0] mem_write_reg;
    logic              mem_access;
    logic              branch_taken;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_write_reg;

    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              pc_en;
    logic              if_id_en;
    logic              id_ex_en;
    logic              ex_mem_en;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              ex_mem_flush;
    logic              mem_wb_bubble;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt,
        output ex_rs, ex_rt, ex_mem_read, ex_write_reg,
        output mem_reg_write, mem_write_reg, mem_access, branch_taken,
        output wb_reg_write, wb_write_reg,
        input  fwd_a, fwd_b,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en,
        input  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  ex_rs, ex_rt, ex_mem_read, ex_write_reg,
        input  mem_reg_write, mem_write_reg, mem_access, branch_taken,
        input  wb_reg_write, wb_write_reg,
        output fwd_a, fwd_b,
        output pc_en, if_id_en, id_ex_en, ex_mem_en,
        output if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
// Produces EX-stage forwarding selects, load-use stalls, taken-branch
// flushes and multi-cycle data-memory wait stalls, plus saturating stall
// and flush counters.
//
// Ports:
//   clk  in  clock, all state updates on posedge
//   rst  in  synchronous active-low reset
//   hz   pipe_hazard_if.slave  datapath status in, stage controls out
//
// Memory-wait FSM:
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | no access in progress; a new access in EX/MEM starts a wait
//   ST_WAIT | access in flight; wcnt counts remaining stall cycles down
//
// Control priority: memory stall > taken branch > load-use.
module pipe_hazard_ctrl #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 32
) (
    input  logic           clk,
    input  logic           rst,
    pipe_hazard_if.slave   hz
);

    // DATA_W drives no logic; it exists so every stage takes the same
    // parameter list. Catch nonsense values at elaboration.
    if (DATA_W < 1) begin : g_bad_data_w
        $error("pipe_hazard_ctrl: DATA_W must be positive");
    end

    // A zero-width counter is illegal, so MEM_LAT=0 still gets one bit.
    localparam int WCNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LOAD =
        (MEM_LAT > 0) ? WCNT_W'(MEM_LAT - 1) : '0;
    localparam logic MEM_MULTI = (MEM_LAT > 0);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state;
    logic [WCNT_W-1:0] wcnt;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  flush_q;

    logic [REG_AW-1:0] id_rs_w, id_rt_w, ex_rs_w, ex_rt_w;
    logic [REG_AW-1:0] ex_wr_w, mem_wr_w, wb_wr_w;

    assign id_rs_w  = hz.id_rs;
    assign id_rt_w  = hz.id_rt;
    assign ex_rs_w  = hz.ex_rs;
    assign ex_rt_w  = hz.ex_rt;
    assign ex_wr_w  = hz.ex_write_reg;
    assign mem_wr_w = hz.mem_write_reg;
    assign wb_wr_w  = hz.wb_write_reg;

    logic ms;
    logic lu;
    logic br;
    logic lu_applied;
    logic mem_fwd_ok;
    logic wb_fwd_ok;

    // ms is Mealy: an access arriving in IDLE must stall that same cycle.
    always_comb begin
        ms = 1'b0;
        case (state)
            ST_IDLE: ms = MEM_MULTI && hz.mem_access;
            ST_WAIT: ms = (wcnt != '0);
            default: ms = 1'b0;
        endcase
    end

    assign lu = hz.ex_mem_read && (ex_wr_w != '0) &&
                ((hz.id_uses_rs && (id_rs_w == ex_wr_w)) ||
                 (hz.id_uses_rt && (id_rt_w == ex_wr_w)));

    assign br         = hz.branch_taken && !ms;
    assign lu_applied = lu && !ms && !hz.branch_taken;

    assign mem_fwd_ok = hz.mem_reg_write && (mem_wr_w != '0);
    assign wb_fwd_ok  = hz.wb_reg_write  && (wb_wr_w  != '0);

    logic [1:0] fwd_a_w, fwd_b_w;
    logic       pc_en_w, if_id_en_w, id_ex_en_w, ex_mem_en_w;
    logic       if_id_fl_w, id_ex_fl_w, ex_mem_fl_w, bubble_w;

    always_comb begin
        fwd_a_w     = 2'b00;
        fwd_b_w     = 2'b00;
        pc_en_w     = 1'b1;
        if_id_en_w  = 1'b1;
        id_ex_en_w  = 1'b1;
        ex_mem_en_w = 1'b1;
        if_id_fl_w  = 1'b0;
        id_ex_fl_w  = 1'b0;
        ex_mem_fl_w = 1'b0;
        bubble_w    = 1'b0;

        if (!rst) begin
            // Hold the whole pipe frozen and filled with NOPs in reset.
            pc_en_w     = 1'b0;
            if_id_en_w  = 1'b0;
            id_ex_en_w  = 1'b0;
            ex_mem_en_w = 1'b0;
            if_id_fl_w  = 1'b1;
            id_ex_fl_w  = 1'b1;
            ex_mem_fl_w = 1'b1;
            bubble_w    = 1'b1;
        end else begin
            // EX/MEM is the younger result, so it wins over MEM/WB.
            if (mem_fwd_ok && (mem_wr_w == ex_rs_w))
                fwd_a_w = 2'b10;
            else if (wb_fwd_ok && (wb_wr_w == ex_rs_w))
                fwd_a_w = 2'b01;

            if (mem_fwd_ok && (mem_wr_w == ex_rt_w))
                fwd_b_w = 2'b10;
            else if (wb_fwd_ok && (wb_wr_w == ex_rt_w))
                fwd_b_w = 2'b01;

            if (ms) begin
                pc_en_w     = 1'b0;
                if_id_en_w  = 1'b0;
                id_ex_en_w  = 1'b0;
                ex_mem_en_w = 1'b0;
                bubble_w    = 1'b1;
            end else if (br) begin
                if_id_fl_w  = 1'b1;
                id_ex_fl_w  = 1'b1;
                ex_mem_fl_w = 1'b1;
            end else if (lu_applied) begin
                // Hold IF/ID and PC, inject a bubble into ID/EX.
                pc_en_w     = 1'b0;
                if_id_en_w  = 1'b0;
                id_ex_fl_w  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            wcnt    <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (MEM_MULTI && hz.mem_access) begin
                        state <= ST_WAIT;
                        wcnt  <= WCNT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (wcnt != '0)
                        wcnt <= wcnt - WCNT_W'(1);
                    else
                        state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    wcnt  <= '0;
                end
            endcase

            if ((ms || lu_applied) && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            if (br && (flush_q != '1))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign hz.fwd_a         = fwd_a_w;
    assign hz.fwd_b         = fwd_b_w;
    assign hz.pc_en         = pc_en_w;
    assign hz.if_id_en      = if_id_en_w;
    assign hz.id_ex_en      = id_ex_en_w;
    assign hz.ex_mem_en     = ex_mem_en_w;
    assign hz.if_id_flush   = if_id_fl_w;
    assign hz.id_ex_flush   = id_ex_fl_w;
    assign hz.ex_mem_flush  = ex_mem_fl_w;
    assign hz.mem_wb_bubble = bubble_w;
    assign hz.stall_cnt     = stall_q;
    assign hz.flush_cnt     = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_write_reg, mem_write_reg, wb_write_reg;
    logic id_uses_rs, id_uses_rt, ex_mem_read, mem_reg_write, mem_access, branch_taken, wb_reg_write;

    pipe_hazard_if #(.REG_AW(5), .CNT_W(32)) hz0 ();
    pipe_hazard_if #(.REG_AW(5), .CNT_W(4))  hz1 ();
    pipe_hazard_if #(.REG_AW(5), .CNT_W(32)) hz2 ();

    pipe_hazard_ctrl #(.DATA_W(32), .REG_AW(5), .MEM_LAT(2), .CNT_W(32)) u_dut  (.clk(clk), .rst(rst), .hz(hz0));
    pipe_hazard_ctrl #(.DATA_W(32), .REG_AW(5), .MEM_LAT(2), .CNT_W(4))  u_sat  (.clk(clk), .rst(rst), .hz(hz1));
    pipe_hazard_ctrl #(.DATA_W(32), .REG_AW(5), .MEM_LAT(0), .CNT_W(32)) u_lat0 (.clk(clk), .rst(rst), .hz(hz2));

    assign hz0.id_rs = id_rs;  assign hz1.id_rs = id_rs;  assign hz2.id_rs = id_rs;
    assign hz0.id_rt = id_rt;  assign hz1.id_rt = id_rt;  assign hz2.id_rt = id_rt;
    assign hz0.id_uses_rs = id_uses_rs; assign hz1.id_uses_rs = id_uses_rs; assign hz2.id_uses_rs = id_uses_rs;
    assign hz0.id_uses_rt = id_uses_rt; assign hz1.id_uses_rt = id_uses_rt; assign hz2.id_uses_rt = id_uses_rt;
    assign hz0.ex_rs = ex_rs;  assign hz1.ex_rs = ex_rs;  assign hz2.ex_rs = ex_rs;
    assign hz0.ex_rt = ex_rt;  assign hz1.ex_rt = ex_rt;  assign hz2.ex_rt = ex_rt;
    assign hz0.ex_mem_read = ex_mem_read; assign hz1.ex_mem_read = ex_mem_read; assign hz2.ex_mem_read = ex_mem_read;
    assign hz0.ex_write_reg = ex_write_reg; assign hz1.ex_write_reg = ex_write_reg; assign hz2.ex_write_reg = ex_write_reg;
    assign hz0.mem_reg_write = mem_reg_write; assign hz1.mem_reg_write = mem_reg_write; assign hz2.mem_reg_write = mem_reg_write;
    assign hz0.mem_write_reg = mem_write_reg; assign hz1.mem_write_reg = mem_write_reg; assign hz2.mem_write_reg = mem_write_reg;
    assign hz0.mem_access = mem_access; assign hz1.mem_access = mem_access; assign hz2.mem_access = mem_access;
    assign hz0.branch_taken = branch_taken; assign hz1.branch_taken = branch_taken; assign hz2.branch_taken = branch_taken;
    assign hz0.wb_reg_write = wb_reg_write; assign hz1.wb_reg_write = wb_reg_write; assign hz2.wb_reg_write = wb_reg_write;
    assign hz0.wb_write_reg = wb_write_reg; assign hz1.wb_write_reg = wb_write_reg; assign hz2.wb_write_reg = wb_write_reg;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Control bundle packed as {pc_en,if_id_en,id_ex_en,ex_mem_en,if_id_fl,id_ex_fl,ex_mem_fl,bubble}
    function automatic logic [31:0] ctl0();
        return {24'd0, hz0.pc_en, hz0.if_id_en, hz0.id_ex_en, hz0.ex_mem_en,
                hz0.if_id_flush, hz0.id_ex_flush, hz0.ex_mem_flush, hz0.mem_wb_bubble};
    endfunction

    localparam logic [31:0] CTL_NONE  = 32'b1111_0000;
    localparam logic [31:0] CTL_MS    = 32'b0000_0001;
    localparam logic [31:0] CTL_BR    = 32'b1111_1110;
    localparam logic [31:0] CTL_LU    = 32'b0011_0100;
    localparam logic [31:0] CTL_RESET = 32'b0000_1111;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0;
        ex_write_reg = '0; mem_write_reg = '0; wb_write_reg = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        mem_reg_write = 1'b0; mem_access = 1'b0; branch_taken = 1'b0; wb_reg_write = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_en [6];
        exp_en[0] = 0; exp_en[1] = 0; exp_en[2] = 1; exp_en[3] = 0; exp_en[4] = 0; exp_en[5] = 1;

        clear_inputs();
        rst = 1'b0;
        tick(); tick();
        settle();
        check("reset_ctl", ctl0(), CTL_RESET);
        check("reset_fwd", {28'd0, hz0.fwd_a, hz0.fwd_b}, 32'd0);
        check("reset_stall", hz0.stall_cnt, 32'd0);
        check("reset_flush", hz0.flush_cnt, 32'd0);

        rst = 1'b1;
        settle();
        check("release_ctl", ctl0(), CTL_NONE);

        // Forwarding
        mem_reg_write = 1'b1; mem_write_reg = 5'd5;
        wb_reg_write  = 1'b1; wb_write_reg  = 5'd5;
        ex_rs = 5'd5; ex_rt = 5'd6;
        settle();
        check("fwd_a_exmem", {30'd0, hz0.fwd_a}, 32'd2);
        check("fwd_b_none", {30'd0, hz0.fwd_b}, 32'd0);
        wb_write_reg = 5'd6;
        settle();
        check("fwd_b_memwb", {30'd0, hz0.fwd_b}, 32'd1);
        check("fwd_a_keep", {30'd0, hz0.fwd_a}, 32'd2);
        mem_write_reg = 5'd0; wb_write_reg = 5'd5;
        settle();
        check("fwd_a_memwb", {30'd0, hz0.fwd_a}, 32'd1);
        mem_write_reg = 5'd0; wb_write_reg = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0;
        settle();
        check("fwd_r0", {28'd0, hz0.fwd_a, hz0.fwd_b}, 32'd0);
        clear_inputs();

        // Load-use
        tick();
        ex_mem_read = 1'b1; ex_write_reg = 5'd8; id_rt = 5'd8; id_uses_rt = 1'b1;
        settle();
        check("lu_ctl", ctl0(), CTL_LU);
        tick();
        check("lu_stall_cnt", hz0.stall_cnt, 32'd1);
        id_uses_rt = 1'b0;
        settle();
        check("lu_unused_ctl", ctl0(), CTL_NONE);
        tick();
        check("lu_unused_cnt", hz0.stall_cnt, 32'd1);
        ex_write_reg = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
        settle();
        check("lu_r0_ctl", ctl0(), CTL_NONE);
        clear_inputs();
        tick();

        // Memory wait, single access of 3 cycles
        mem_access = 1'b1;
        settle();
        check("ms_a_ctl", ctl0(), CTL_MS);
        check("lat0_no_stall", {31'd0, hz2.ex_mem_en}, 32'd1);
        tick();
        check("ms_b_ctl", ctl0(), CTL_MS);
        tick();
        check("ms_c_ctl", ctl0(), CTL_NONE);
        check("lat0_stall_cnt", hz2.stall_cnt, 32'd1);
        tick();
        mem_access = 1'b0;
        settle();
        check("ms_stall_cnt", hz0.stall_cnt, 32'd3);

        // Back-to-back accesses
        mem_access = 1'b1;
        for (int i = 0; i < 6; i++) begin
            settle();
            check($sformatf("b2b_en_%0d", i), {31'd0, hz0.ex_mem_en}, exp_en[i]);
            tick();
        end
        mem_access = 1'b0;
        settle();
        check("b2b_stall_cnt", hz0.stall_cnt, 32'd7);

        // Branch over load-use
        ex_mem_read = 1'b1; ex_write_reg = 5'd8; id_rt = 5'd8; id_uses_rt = 1'b1;
        branch_taken = 1'b1;
        settle();
        check("br_lu_ctl", ctl0(), CTL_BR);
        tick();
        check("br_flush_cnt", hz0.flush_cnt, 32'd1);
        check("br_stall_cnt", hz0.stall_cnt, 32'd7);
        clear_inputs();

        // Branch during memory stall is ignored
        mem_access = 1'b1; branch_taken = 1'b1;
        settle();
        check("br_ms_ctl", ctl0(), CTL_MS);
        tick();
        branch_taken = 1'b0;
        tick();
        tick();
        mem_access = 1'b0;
        settle();
        check("br_ms_flush_cnt", hz0.flush_cnt, 32'd1);
        check("br_ms_stall_cnt", hz0.stall_cnt, 32'd9);

        // Reset during WAIT
        mem_access = 1'b1;
        tick();
        mem_reg_write = 1'b1; mem_write_reg = 5'd5; ex_rs = 5'd5;
        rst = 1'b0;
        settle();
        check("rstw_ctl", ctl0(), CTL_RESET);
        check("rstw_fwd", {28'd0, hz0.fwd_a, hz0.fwd_b}, 32'd0);
        tick();
        check("rstw_stall", hz0.stall_cnt, 32'd0);
        check("rstw_flush", hz0.flush_cnt, 32'd0);
        rst = 1'b1;
        clear_inputs();
        settle();
        check("rstw_release_ctl", ctl0(), CTL_NONE);
        tick();
        check("rstw_release_stall", hz0.stall_cnt, 32'd0);

        // Saturation with CNT_W=4
        ex_mem_read = 1'b1; ex_write_reg = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        clear_inputs();
        settle();
        check("sat_cnt4", {28'd0, hz1.stall_cnt}, 32'd15);
        check("sat_cnt32", hz0.stall_cnt, 32'd20);
        tick();
        check("sat_hold", {28'd0, hz1.stall_cnt}, 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
